// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared types and helpers for the round-robin grant stage
package rr_grant_pkg;
  localparam int MAX_W = 256;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  function automatic logic [MAX_W-1:0] idx2oht(input logic [7:0] idx);
    return {{(MAX_W-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/programmable_priority_encoder.sv
// programmable_priority_encoder: first set bit at or after enc_pri, high vector before low
module programmable_priority_encoder import rr_grant_pkg::*; #(
  parameter int WIDTH = 4,
  localparam int WL = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] dec_vld_h,
  input  logic [WIDTH-1:0] dec_vld_l,
  input  logic [WL-1:0]    enc_pri,
  output logic [WL-1:0]    enc_idx,
  output logic             enc_vld
);
  logic [WIDTH-1:0] w_sel;
  logic [WL:0]      w_t;
  assign w_sel   = |dec_vld_h ? dec_vld_h : dec_vld_l;
  assign enc_vld = |w_sel;
  // descending scan so the candidate closest to the pointer is written last
  always_comb begin
    enc_idx = '0;
    w_t = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      w_t = {1'b0, enc_pri} + (WL+1)'(j);
      if (w_t >= (WL+1)'(WIDTH)) w_t = w_t - (WL+1)'(WIDTH);
      if (w_sel[w_t[WL-1:0]]) enc_idx = w_t[WL-1:0];
    end
  end
endmodule

// File: rtl/rr_grant_decoder.sv
// rr_grant_decoder: registered round-robin grant with valid/ready hold and rotating pointer
module rr_grant_decoder import rr_grant_pkg::*; #(
  parameter int WIDTH = 4,
  localparam int WIDTH_LOG = idx_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic                 pri_ld,
  input  logic [WIDTH_LOG-1:0] pri_val,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] pri
);
  state_t               r_state, w_state_nxt;
  logic [WIDTH_LOG-1:0] r_idx, r_pri, w_pri_nxt, w_enc_idx;
  logic [WIDTH-1:0]     r_oht, w_req_m, w_new_oht;
  logic                 w_hs, w_ld_ok, w_issue, w_enc_vld, w_open;
  always_comb begin
    w_hs = (r_state == GRANT) && gnt_rdy;
    w_open = (r_state == IDLE) || w_hs;
    w_ld_ok = pri_ld && w_open && ({1'b0, pri_val} < (WIDTH_LOG+1)'(WIDTH));
    w_pri_nxt = w_ld_ok ? pri_val :
                w_hs ? ((r_idx == WIDTH_LOG'(WIDTH-1)) ? '0 : r_idx + 1'b1) : r_pri;
    w_req_m = req & ~(w_hs ? r_oht : '0);
    w_issue = w_enc_vld && !pri_ld && w_open;
    w_state_nxt = w_issue ? GRANT : w_hs ? IDLE : r_state;
  end
  programmable_priority_encoder #(.WIDTH(WIDTH)) u_ppe (
    .dec_vld_h(w_req_m),
    .dec_vld_l('0),
    .enc_pri(w_pri_nxt),
    .enc_idx(w_enc_idx),
    .enc_vld(w_enc_vld)
  );
  assign w_new_oht = WIDTH'(idx2oht(8'(w_enc_idx)));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_oht <= '0;
      r_pri <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pri <= w_pri_nxt;
      if (w_issue) begin
        r_idx <= w_enc_idx;
        r_oht <= w_new_oht;
      end else if (w_hs) begin
        r_oht <= '0;
      end
    end
  end
  assign gnt_vld = (r_state == GRANT);
  assign gnt_idx = r_idx;
  assign gnt_oht = r_oht;
  assign pri     = r_pri;
endmodule

// File: tb/tb_rr_grant_decoder.sv
// tb_rr_grant_decoder: table vectors on WIDTH=4 plus model-scoreboarded random run on WIDTH=3
module tb_rr_grant_decoder;
  import rr_grant_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic       rst4 = 1, pri_ld4 = 0, gnt_rdy4 = 0, gnt_vld4;
  logic [3:0] req4 = 0, gnt_oht4;
  logic [1:0] pri_val4 = 0, gnt_idx4, pri4;
  logic       rst3 = 1, pri_ld3 = 0, gnt_rdy3 = 0, gnt_vld3;
  logic [2:0] req3 = 0, gnt_oht3;
  logic [1:0] pri_val3 = 0, gnt_idx3, pri3;
  rr_grant_decoder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .req(req4), .pri_ld(pri_ld4), .pri_val(pri_val4),
    .gnt_vld(gnt_vld4), .gnt_rdy(gnt_rdy4), .gnt_idx(gnt_idx4), .gnt_oht(gnt_oht4), .pri(pri4)
  );
  rr_grant_decoder #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst3), .req(req3), .pri_ld(pri_ld3), .pri_val(pri_val3),
    .gnt_vld(gnt_vld3), .gnt_rdy(gnt_rdy3), .gnt_idx(gnt_idx3), .gnt_oht(gnt_oht3), .pri(pri3)
  );
  typedef struct {
    logic rst; logic [3:0] req; logic ld; logic [1:0] pv; logic rdy;
    logic vld; logic [1:0] idx; logic [3:0] oht; logic [1:0] pri;
  } vec_t;
  typedef struct {logic vld; logic [1:0] idx; logic [3:0] oht; logic [1:0] pri;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int total = 0, bad = 0;
  bit m_vld = 0, fair_on = 0;
  int m_idx = 0, m_pri = 0, max_wait = 0;
  int wt[3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [3:0] rq, input logic ld, input logic [1:0] pv,
                     input logic rdy, input logic v, input logic [1:0] ix, input logic [3:0] oh,
                     input logic [1:0] p);
    tbl.push_back(vec_t'{r, rq, ld, pv, rdy, v, ix, oh, p});
  endtask
  task automatic run4(input vec_t v, input int n);
    exp_t e;
    rst4 = v.rst; req4 = v.req; pri_ld4 = v.ld; pri_val4 = v.pv; gnt_rdy4 = v.rdy;
    sb.push_back(exp_t'{v.vld, v.idx, v.oht, v.pri});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("w4_vld[%0d]", n), 32'(gnt_vld4), 32'(e.vld));
    chk($sformatf("w4_idx[%0d]", n), 32'(gnt_idx4), 32'(e.idx));
    chk($sformatf("w4_oht[%0d]", n), 32'(gnt_oht4), 32'(e.oht));
    chk($sformatf("w4_pri[%0d]", n), 32'(pri4), 32'(e.pri));
  endtask
  function automatic int find(input logic [2:0] r, input int p);
    for (int j = 0; j < 3; j++) begin
      int k;
      k = (p + j) % 3;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction
  task automatic step3(input logic r, input logic [2:0] rq, input logic ld, input logic [1:0] pv,
                       input logic rdy);
    bit hs;
    int np, w, old;
    logic [2:0] m;
    exp_t e;
    rst3 = r; req3 = rq; pri_ld3 = ld; pri_val3 = pv; gnt_rdy3 = rdy;
    old = m_idx;
    hs = 0;
    if (r) begin
      m_vld = 0; m_idx = 0; m_pri = 0;
    end else begin
      hs = m_vld && rdy;
      np = m_pri;
      if (hs) np = (m_idx + 1) % 3;
      if (ld && (!m_vld || hs) && pv < 3) np = int'(pv);
      m = rq;
      if (hs) m[old[1:0]] = 1'b0;
      if (!m_vld || hs) begin
        w = find(m, np);
        if (!ld && w >= 0) begin
          m_vld = 1; m_idx = w;
        end else m_vld = 0;
      end
      m_pri = np;
      if (fair_on)
        for (int i = 0; i < 3; i++) begin
          if (!rq[i[1:0]]) wt[i] = 0;
          else if (hs && old != i) wt[i]++;
          if (wt[i] > max_wait) max_wait = wt[i];
          if (m_vld && m_idx == i) wt[i] = 0;
        end
    end
    sb.push_back(exp_t'{m_vld, 2'(m_idx), m_vld ? 4'(idx2oht(8'(m_idx))) : 4'b0, 2'(m_pri)});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("w3_vld", 32'(gnt_vld3), 32'(e.vld));
    chk("w3_idx", 32'(gnt_idx3), 32'(e.idx));
    chk("w3_oht", 32'(gnt_oht3), 32'(e.oht));
    chk("w3_pri", 32'(pri3), 32'(e.pri));
  endtask
  initial begin
    logic [2:0] rq;
    add(1, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 1, 1, 0, 4'h1, 0);
    add(0, 4'hF, 0, 0, 1, 1, 1, 4'h2, 1);
    add(0, 4'hF, 0, 0, 1, 1, 2, 4'h4, 2);
    add(0, 4'hF, 0, 0, 1, 1, 3, 4'h8, 3);
    add(0, 4'hF, 0, 0, 1, 1, 0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 1, 0, 0, 4'h0, 1);
    add(0, 4'h0, 1, 2, 0, 0, 0, 4'h0, 2);
    add(0, 4'h3, 0, 0, 0, 1, 0, 4'h1, 2);
    add(0, 4'h2, 0, 0, 0, 1, 0, 4'h1, 2);
    add(0, 4'h2, 0, 0, 0, 1, 0, 4'h1, 2);
    add(0, 4'h2, 1, 3, 0, 1, 0, 4'h1, 2);
    add(0, 4'h2, 0, 0, 1, 1, 1, 4'h2, 1);
    add(0, 4'h0, 1, 3, 1, 0, 1, 4'h0, 3);
    add(0, 4'h9, 1, 3, 0, 0, 1, 4'h0, 3);
    add(0, 4'h9, 0, 0, 0, 1, 3, 4'h8, 3);
    add(0, 4'h9, 1, 0, 1, 0, 3, 4'h0, 0);
    add(0, 4'h9, 0, 0, 0, 1, 0, 4'h1, 0);
    add(0, 4'h9, 0, 0, 1, 1, 3, 4'h8, 1);
    add(1, 4'h9, 0, 0, 0, 0, 0, 4'h0, 0);
    add(0, 4'h4, 0, 0, 0, 1, 2, 4'h4, 0);
    foreach (tbl[i]) run4(tbl[i], i);
    step3(1, 3'b000, 0, 0, 0);
    step3(0, 3'b000, 1, 2, 0);
    step3(0, 3'b111, 1, 3, 0);
    chk("w3_pri_out_of_range", 32'(pri3), 32'd2);
    chk("w3_blocked_by_ld", 32'(gnt_vld3), 32'd0);
    step3(0, 3'b001, 0, 0, 0);
    chk("w3_wrap_grant", 32'(gnt_idx3), 32'd0);
    rq = 3'b111;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      step3($urandom_range(0, 199) == 0, rq, $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    fair_on = 1;
    for (int i = 0; i < 3; i++) wt[i] = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 3'($urandom_range(0, 7));
      step3(0, rq, 0, 0, 1'($urandom_range(0, 1)));
    end
    total++;
    if (max_wait > 3) begin
      bad++;
      $display("FAIL fairness max_wait=%0d required<=3", max_wait);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_grant_decoder.md
Name: rr_grant_decoder

Overview:
- Registered round-robin grant stage for a multi-requester bus.
- Searches the request vector starting at a rotating priority pointer and issues the winner as both a registered binary index and a one-hot grant.
- Holds the grant under a valid/ready handshake, then advances the pointer past the winner.
- Sits downstream of request aggregation and drives per-requester grant lines and the mux select.

Parameters:
WIDTH, 4, number of requesters; legal range 2..256; non-power-of-2 allowed
WIDTH_LOG, $clog2(WIDTH), localparam, index and pointer width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
req  input  WIDTH  level requests; bit i = requester i
pri_ld  input  1  load priority pointer
pri_val  input  WIDTH_LOG  value for pointer load
gnt_vld  output  1  grant valid
gnt_rdy  input  1  downstream accepts the grant
gnt_idx  output  WIDTH_LOG  binary index of the granted requester
gnt_oht  output  WIDTH  one-hot grant; equals 1<<gnt_idx while gnt_vld, else zero
pri  output  WIDTH_LOG  current priority pointer (requester searched first)

Behaviour:
- Reset: gnt_vld=0, gnt_idx=0, gnt_oht=0, pri=0, FSM=IDLE. Reset mid-grant drops the grant without a handshake; pri returns to 0.
- FSM has two states, IDLE and GRANT.
- Arbitration (combinational): winner = first t = (j+pri) mod WIDTH, j=0..WIDTH-1, with req[t]=1. Modulo is taken over WIDTH, not 2^WIDTH_LOG.
- IDLE: if |req and !pri_ld, register winner into gnt_idx/gnt_oht, set gnt_vld=1, go to GRANT. Latency: req to gnt_vld is 1 cycle.
- GRANT: gnt_idx, gnt_oht and gnt_vld are held stable until gnt_vld&gnt_rdy. A request dropping meanwhile does not revoke the grant.
- Handshake cycle:
  - pri <= (gnt_idx+1) mod WIDTH; WIDTH-1 wraps to 0.
  - If req has any bit set other than the just-granted one, stay in GRANT. Register a new winner, searched from the updated pointer and excluding the just-granted bit. The result is back-to-back grants with zero idle cycles.
  - Otherwise gnt_vld=0, gnt_oht=0, go to IDLE. gnt_idx keeps its last value.
- pri_ld is honoured only in IDLE or in a handshake cycle; in GRANT without a handshake it is ignored.
  - When honoured it overrides the post-grant increment.
  - No new grant is issued in that cycle; arbitration resumes next cycle with the loaded pointer.
  - pri_val >= WIDTH: pointer unchanged, but issue is still blocked that cycle.
- Invariants: gnt_oht is zero or exactly one-hot, and gnt_oht==(gnt_vld ? 1<<gnt_idx : 0).
- Fairness: with all requests held, every requester is granted once per WIDTH handshakes.

Decomposition:
- Package rr_grant_pkg holds:
  - index-width helper function;
  - function idx2oht(index) returning the one-hot vector, used by RTL and bench;
  - state enum {IDLE, GRANT}.
- Sub-module: one instance of the existing programmable_priority_encoder performs the search.
  - dec_vld_h = req masked by the just-granted bit on handshake;
  - dec_vld_l = 0;
  - enc_pri = next pointer.
- rr_grant_decoder adds the FSM, pointer register, and one-hot decode.

Test Plan:
1. Reset then req=4'b0000 for 5 cycles -> gnt_vld=0, gnt_oht=0, pri=0.
2. WIDTH=4, req=4'b1111 held, gnt_rdy=1 -> gnt_idx sequence 0,1,2,3,0 on consecutive cycles; pri 1,2,3,0; gnt_vld never drops.
3. pri=2, req=4'b0011 -> gnt_idx=0 (wrap past 3). gnt_rdy=0 for 3 cycles while req changes to 4'b0010 -> gnt_idx stays 0, gnt_oht=4'b0001 stable.
4. In IDLE, pri_ld=1, pri_val=3 with req=4'b1001 -> no grant that cycle; next cycle gnt_idx=3, gnt_oht=4'b1000. Then pri_val=5 with WIDTH=5 -> pointer unchanged.
5. rst asserted while gnt_vld=1 and gnt_rdy=0 -> next cycle gnt_vld=0, pri=0. First grant after release with req=4'b0100 is idx 2.
6. WIDTH=3 random req/gnt_rdy/pri_ld, 10k cycles -> bench model matches gnt_idx, pri and gnt_oht invariant every cycle; no requester waits more than 3 handshakes while requesting.
